// File: rtl/character_controller.sv
// Overworld player controller: turns the keyboard keycode into tile-grid
// motion, paced by one step per video frame.
module character_controller #(
  parameter int TILE_PX     = 16,
  parameter int STEP_PX     = 2,
  parameter int TURN_FRAMES = 4,
  parameter int MAP_W       = 32,
  parameter int MAP_H       = 32,
  parameter int START_X     = 8,
  parameter int START_Y     = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [1:0] Direction,
  output logic       Character_Moving,
  output logic       Anim_Foot,
  output logic [5:0] Tile_X,
  output logic [5:0] Tile_Y,
  output logic [4:0] Pixel_Offset
);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_WALK} state_t;

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [4:0] LP_STEP      = 5'(STEP_PX);
  localparam logic [4:0] LP_TILE      = 5'(TILE_PX);
  localparam logic [3:0] LP_TURN_INIT = 4'(TURN_FRAMES - 1);
  localparam logic [5:0] LP_MAX_X     = 6'(MAP_W - 1);
  localparam logic [5:0] LP_MAX_Y     = 6'(MAP_H - 1);
  localparam logic [5:0] LP_START_X   = 6'(START_X);
  localparam logic [5:0] LP_START_Y   = 6'(START_Y);

  logic [2:0] r_sync;
  logic       r_tick;
  state_t     r_state;
  logic [1:0] r_dir;
  logic       r_moving;
  logic       r_foot;
  logic [5:0] r_tx;
  logic [5:0] r_ty;
  logic [4:0] r_off;
  logic [3:0] r_turnCnt;

  logic       w_reqValid;
  logic [1:0] w_reqDir;
  logic [4:0] w_offNext;
  logic [5:0] w_stepX;
  logic [5:0] w_stepY;

  // A move toward d from (x,y) would leave the map.
  function automatic logic isBlocked(input logic [5:0] x, input logic [5:0] y,
                                     input logic [1:0] d);
    case (d)
      DIR_DOWN: isBlocked = (y == LP_MAX_Y);
      DIR_UP:   isBlocked = (y == 6'd0);
      DIR_LEFT: isBlocked = (x == 6'd0);
      default:  isBlocked = (x == LP_MAX_X);
    endcase
  endfunction

  // Bring vsync into the Clk domain and make a one-cycle pulse on its rise.
  always_ff @(posedge Clk) begin
    r_sync <= {r_sync[1:0], frame_clk};
    r_tick <= r_sync[1] & ~r_sync[2];
  end

  // Map WASD keycodes onto a requested facing; anything else requests nothing.
  always_comb begin
    w_reqValid = 1'b1;
    w_reqDir   = DIR_DOWN;
    case (keycode)
      8'h1A:   w_reqDir = DIR_UP;
      8'h16:   w_reqDir = DIR_DOWN;
      8'h04:   w_reqDir = DIR_LEFT;
      8'h07:   w_reqDir = DIR_RIGHT;
      default: w_reqValid = 1'b0;
    endcase
  end

  // Next pixel offset and the neighbouring tile in the current facing.
  always_comb begin
    w_offNext = r_off + LP_STEP;
    w_stepX   = r_tx;
    w_stepY   = r_ty;
    case (r_dir)
      DIR_DOWN: w_stepY = r_ty + 6'd1;
      DIR_UP:   w_stepY = r_ty - 6'd1;
      DIR_LEFT: w_stepX = r_tx - 6'd1;
      default:  w_stepX = r_tx + 6'd1;
    endcase
  end

  // Movement FSM; advances only on frame ticks, reset overrides any tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_dir     <= DIR_DOWN;
      r_moving  <= 1'b0;
      r_foot    <= 1'b0;
      r_tx      <= LP_START_X;
      r_ty      <= LP_START_Y;
      r_off     <= '0;
      r_turnCnt <= '0;
    end else if (r_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_reqValid) begin
            if (w_reqDir != r_dir) begin
              r_dir     <= w_reqDir;
              r_turnCnt <= LP_TURN_INIT;
              r_state   <= S_TURN;
            end else if (!isBlocked(r_tx, r_ty, r_dir)) begin
              r_state  <= S_WALK;
              r_moving <= 1'b1;
              r_off    <= LP_STEP;
            end
          end
        end
        S_TURN: begin
          if (r_turnCnt != 4'd0) begin
            r_turnCnt <= r_turnCnt - 4'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WALK: begin
          if (w_offNext < LP_TILE) begin
            r_off <= w_offNext;
          end else begin
            r_tx   <= w_stepX;
            r_ty   <= w_stepY;
            r_foot <= ~r_foot;
            if (w_reqValid && (w_reqDir == r_dir) &&
                !isBlocked(w_stepX, w_stepY, r_dir)) begin
              r_off <= LP_STEP;
            end else begin
              r_off    <= '0;
              r_state  <= S_IDLE;
              r_moving <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign Direction        = r_dir;
  assign Character_Moving = r_moving;
  assign Anim_Foot        = r_foot;
  assign Tile_X           = r_tx;
  assign Tile_Y           = r_ty;
  assign Pixel_Offset     = r_off;

endmodule

// File: tb/tb_character_controller.sv
// Randomised and directed bench for character_controller, checked against a
// tick-level behavioural model of player motion.
module tb_character_controller;

  localparam int TILE_PX     = 16;
  localparam int STEP_PX     = 2;
  localparam int TURN_FRAMES = 4;
  localparam int MAP_W       = 32;
  localparam int MAP_H       = 32;
  localparam int START_X     = 8;
  localparam int START_Y     = 8;

  localparam int M_IDLE = 0;
  localparam int M_TURN = 1;
  localparam int M_WALK = 2;

  logic       clk;
  logic       reset;
  logic       frameClk;
  logic [7:0] keycode;
  logic [1:0] direction;
  logic       moving;
  logic       foot;
  logic [5:0] tileX;
  logic [5:0] tileY;
  logic [4:0] pixelOffset;

  int checkCount;
  int passCount;

  int mState;
  int mDir;
  int mX;
  int mY;
  int mOff;
  int mFoot;
  int mTurnLeft;

  character_controller #(
    .TILE_PX(TILE_PX), .STEP_PX(STEP_PX), .TURN_FRAMES(TURN_FRAMES),
    .MAP_W(MAP_W), .MAP_H(MAP_H), .START_X(START_X), .START_Y(START_Y)
  ) dut (
    .Clk(clk),
    .Reset(reset),
    .frame_clk(frameClk),
    .keycode(keycode),
    .Direction(direction),
    .Character_Moving(moving),
    .Anim_Foot(foot),
    .Tile_X(tileX),
    .Tile_Y(tileY),
    .Pixel_Offset(pixelOffset)
  );

  // 50 MHz system clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic int dxOf(input int d);
    if (d == 2) return -1;
    if (d == 3) return 1;
    return 0;
  endfunction

  function automatic int dyOf(input int d);
    if (d == 0) return 1;
    if (d == 1) return -1;
    return 0;
  endfunction

  function automatic bit offMap(input int x, input int y, input int d);
    int tx;
    int ty;
    tx = x + dxOf(d);
    ty = y + dyOf(d);
    return (tx < 0) || (tx >= MAP_W) || (ty < 0) || (ty >= MAP_H);
  endfunction

  // Returns facing requested by a keycode, or -1 for no request.
  function automatic int keyToDir(input logic [7:0] k);
    case (k)
      8'h1A:   return 1;
      8'h16:   return 0;
      8'h04:   return 2;
      8'h07:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic modelReset();
    mState    = M_IDLE;
    mDir      = 0;
    mX        = START_X;
    mY        = START_Y;
    mOff      = 0;
    mFoot     = 0;
    mTurnLeft = 0;
  endtask

  // One frame of player behaviour under keycode k.
  task automatic modelTick(input logic [7:0] k);
    int req;
    req = keyToDir(k);
    if (mState == M_IDLE) begin
      if (req >= 0) begin
        if (req != mDir) begin
          mDir      = req;
          mTurnLeft = TURN_FRAMES - 1;
          mState    = M_TURN;
        end else if (!offMap(mX, mY, mDir)) begin
          mState = M_WALK;
          mOff   = STEP_PX;
        end
      end
    end else if (mState == M_TURN) begin
      if (mTurnLeft > 0) mTurnLeft--;
      else mState = M_IDLE;
    end else begin
      if (mOff + STEP_PX < TILE_PX) begin
        mOff += STEP_PX;
      end else begin
        mX    += dxOf(mDir);
        mY    += dyOf(mDir);
        mFoot ^= 1;
        if (req == mDir && !offMap(mX, mY, mDir)) begin
          mOff = STEP_PX;
        end else begin
          mOff   = 0;
          mState = M_IDLE;
        end
      end
    end
  endtask

  task automatic checkVal(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_dir"},    int'(direction),   mDir);
    checkVal({tag, "_moving"}, int'(moving),      (mState == M_WALK) ? 1 : 0);
    checkVal({tag, "_foot"},   int'(foot),        mFoot);
    checkVal({tag, "_x"},      int'(tileX),       mX);
    checkVal({tag, "_y"},      int'(tileY),       mY);
    checkVal({tag, "_off"},    int'(pixelOffset), mOff);
  endtask

  task automatic checkResetLiterals(input string tag);
    checkVal({tag, "_dir"},    int'(direction),   0);
    checkVal({tag, "_moving"}, int'(moving),      0);
    checkVal({tag, "_foot"},   int'(foot),        0);
    checkVal({tag, "_x"},      int'(tileX),       8);
    checkVal({tag, "_y"},      int'(tileY),       8);
    checkVal({tag, "_off"},    int'(pixelOffset), 0);
  endtask

  // One vsync pulse with key held throughout, then model update and compare.
  task automatic applyStimulus(input logic [7:0] k);
    keycode  = k;
    frameClk = 1'b1;
    repeat (3) @(negedge clk);
    frameClk = 1'b0;
    repeat (4) @(negedge clk);
    modelTick(k);
    checkOutput("tick");
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput("reset");
  endtask

  // Directed scenarios, then a long randomised run.
  initial begin
    logic [7:0] heldKey;
    logic [7:0] keyTable [8];
    keyTable[0] = 8'h00; keyTable[1] = 8'h1A; keyTable[2] = 8'h16;
    keyTable[3] = 8'h04; keyTable[4] = 8'h07; keyTable[5] = 8'h2C;
    keyTable[6] = 8'h07; keyTable[7] = 8'h1A;
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    frameClk   = 1'b0;
    keycode    = 8'h00;
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("init");
    checkResetLiterals("init_lit");

    // Turn right, then four ticks stuck turning even with the key held.
    applyStimulus(8'h07);
    checkVal("turn_dir_lit", int'(direction), 3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h07);
      checkVal("turn_still_lit", int'(moving), 0);
    end
    checkVal("turn_x_lit", int'(tileX), 8);

    // One tile right with a single tap.
    applyStimulus(8'h07);
    checkVal("walk_start_moving_lit", int'(moving), 1);
    checkVal("walk_start_off_lit", int'(pixelOffset), 2);
    for (int i = 0; i < 7; i++) applyStimulus(8'h00);
    checkVal("walk_x_lit", int'(tileX), 9);
    checkVal("walk_off_lit", int'(pixelOffset), 0);
    checkVal("walk_foot_lit", int'(foot), 1);
    checkVal("walk_moving_lit", int'(moving), 0);

    // Continuous walk: moving never drops between tiles.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(8'h07);
      checkVal("cont_moving_lit", int'(moving), 1);
    end
    checkVal("cont_x_lit", int'(tileX), 12);
    checkVal("cont_foot_lit", int'(foot), 0);
    for (int i = 0; i < 7; i++) applyStimulus(8'h00);
    checkVal("cont_end_x_lit", int'(tileX), 13);

    // Reset in the middle of a step.
    applyStimulus(8'h07);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00);
    checkVal("mid_off_lit", int'(pixelOffset), 8);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    modelReset();
    checkResetLiterals("midreset_lit");
    @(negedge clk);
    reset = 1'b0;

    // Space bar does nothing.
    applyStimulus(8'h2C);
    applyStimulus(8'h2C);
    checkResetLiterals("space_lit");

    // Walk up to the top edge and push against it.
    applyStimulus(8'h1A);
    for (int i = 0; i < 4; i++) applyStimulus(8'h00);
    for (int i = 0; i < 64; i++) applyStimulus(8'h1A);
    checkVal("edge_y_lit", int'(tileY), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h1A);
      checkVal("edge_moving_lit", int'(moving), 0);
      checkVal("edge_hold_y_lit", int'(tileY), 0);
    end
    checkVal("edge_dir_lit", int'(direction), 1);
    applyStimulus(8'h16);
    for (int i = 0; i < 4; i++) applyStimulus(8'h00);
    applyStimulus(8'h16);
    for (int i = 0; i < 7; i++) applyStimulus(8'h00);
    checkVal("edge_back_y_lit", int'(tileY), 1);

    // A frame tick arriving while reset is held must be discarded.
    @(negedge clk);
    reset    = 1'b1;
    keycode  = 8'h04;
    frameClk = 1'b1;
    repeat (3) @(negedge clk);
    frameClk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("tick_in_reset");

    // Randomised key holds with occasional resets.
    heldKey = 8'h00;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) == 0) heldKey = 8'($urandom_range(0, 255));
        else heldKey = keyTable[$urandom_range(0, 7)];
      end
      if ($urandom_range(0, 79) == 0) applyReset();
      else applyStimulus(heldKey);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
